addr_decoder_mr: RTL and testbench

Parametrised multi-region address decoder that generalises the single-region program-memory chip-select decode into N configurable base/mask windows. Each access is registered. A one-hot chip select and a per-region wait-state countdown end the access with a `ready` pulse. Accesses that hit no region raise a registered bus-error pulse and latch the offending address. The block sits between the CPU memory-request path and the program/data/peripheral memories.

---
 rtl/addr_dec_pkg.sv | 22 ++
 rtl/addr_region_match.sv | 28 ++
 rtl/addr_decoder_mr.sv | 125 ++++++++++++
 tb/tb_addr_decoder_mr.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_dec_pkg.sv
// Shared types and constants for the multi-region address decoder.
package addr_dec_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      ERR    = 2'd2
   } state_t;

   localparam int unsigned WAIT_W   = 4;
   localparam int unsigned ERRCNT_W = 8;

   // Default program-memory window (0x4000-0x47FF).
   localparam logic [31:0] PROG_BASE = 32'h0000_4000;
   localparam logic [31:0] PROG_MASK = 32'hFFFF_F800;

   // Region index width; at least one bit so a single-region build still has a port.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/addr_region_match.sv
// Combinational base/mask window match; the lowest matching region index wins.
module addr_region_match
   import addr_dec_pkg::*;
#(
   parameter int unsigned              ADDR_W = 32,
   parameter int unsigned              N_REG  = 4,
   parameter logic [N_REG*ADDR_W-1:0]  BASE   = '0,
   parameter logic [N_REG*ADDR_W-1:0]  MASK   = '0,
   localparam int unsigned             IDX_W  = idx_width(N_REG)
) (
   input  logic [ADDR_W-1:0] addr,
   output logic              hit,
   output logic [IDX_W-1:0]  idx
);

   // Scan from the top down so a lower-index match overwrites a higher one.
   always_comb begin
      hit = 1'b0;
      idx = '0;
      for (int i = int'(N_REG) - 1; i >= 0; i--) begin
         if ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
            hit = 1'b1;
            idx = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/addr_decoder_mr.sv
// Multi-region address decoder: registered one-hot chip select, per-region
// wait-state countdown ending in a ready pulse, and unmapped-access reporting.
module addr_decoder_mr
   import addr_dec_pkg::*;
#(
   parameter int unsigned              ADDR_W = 32,
   parameter int unsigned              N_REG  = 4,
   parameter logic [N_REG*ADDR_W-1:0]  BASE   = {32'h0000_0000, 32'h0000_8000,
                                                 32'h0000_2000, PROG_BASE},
   parameter logic [N_REG*ADDR_W-1:0]  MASK   = {32'hFFFF_FF00, 32'hFFFF_C000,
                                                 32'hFFFF_F000, PROG_MASK},
   parameter logic [N_REG*WAIT_W-1:0]  WAIT   = {4'd0, 4'd3, 4'd1, 4'd0}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req,
   input  logic [ADDR_W-1:0]   addr,
   output logic [N_REG-1:0]    cs,
   output logic                ready,
   output logic                bus_err,
   output logic [ADDR_W-1:0]   err_addr,
   output logic [ERRCNT_W-1:0] err_cnt,
   output logic                busy
);

   localparam int unsigned IDX_W = idx_width(N_REG);

   state_t                state_q, state_d;
   logic [WAIT_W-1:0]     wcnt_q, wcnt_d;
   logic [N_REG-1:0]      cs_q, cs_d;
   logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
   logic [ERRCNT_W-1:0]   err_cnt_q, err_cnt_d;
   logic                  ready_q, ready_d;
   logic                  bus_err_q, bus_err_d;
   logic                  busy_q, busy_d;
   logic                  hit;
   logic [IDX_W-1:0]      idx;

   addr_region_match #(
      .ADDR_W (ADDR_W),
      .N_REG  (N_REG),
      .BASE   (BASE),
      .MASK   (MASK)
   ) u_match (
      .addr (addr),
      .hit  (hit),
      .idx  (idx)
   );

   // Next-state and next-output decode; status outputs follow the next state.
   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      cs_d       = cs_q;
      err_addr_d = err_addr_q;
      err_cnt_d  = err_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  state_d = ACCESS;
                  wcnt_d  = WAIT[int'(idx)*WAIT_W +: WAIT_W];
                  cs_d    = N_REG'(1) << idx;
               end else begin
                  state_d    = ERR;
                  err_addr_d = addr;
                  if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
                     err_cnt_d = err_cnt_q + ERRCNT_W'(1);
                  end
               end
            end
         end
         ACCESS: begin
            if (wcnt_q != '0) begin
               wcnt_d = wcnt_q - WAIT_W'(1);
            end else begin
               state_d = IDLE;
               cs_d    = '0;
            end
         end
         ERR: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            cs_d    = '0;
            wcnt_d  = '0;
         end
      endcase
      ready_d   = (state_d == ACCESS) && (wcnt_d == '0);
      bus_err_d = (state_d == ERR);
      busy_d    = (state_d != IDLE);
   end

   // State, counter and output registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         cs_q       <= '0;
         err_addr_q <= '0;
         err_cnt_q  <= '0;
         ready_q    <= 1'b0;
         bus_err_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         cs_q       <= cs_d;
         err_addr_q <= err_addr_d;
         err_cnt_q  <= err_cnt_d;
         ready_q    <= ready_d;
         bus_err_q  <= bus_err_d;
         busy_q     <= busy_d;
      end
   end

   assign cs       = cs_q;
   assign ready    = ready_q;
   assign bus_err  = bus_err_q;
   assign err_addr = err_addr_q;
   assign err_cnt  = err_cnt_q;
   assign busy     = busy_q;

endmodule

// File: tb/tb_addr_decoder_mr.sv
// Self-checking bench for addr_decoder_mr: default map plus an overlapping map.
module tb_addr_decoder_mr;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        ov_req;
   logic [31:0] addr;

   logic [3:0]  cs, ov_cs;
   logic        ready, ov_ready;
   logic        bus_err, ov_bus_err;
   logic [31:0] err_addr, ov_err_addr;
   logic [7:0]  err_cnt, ov_err_cnt;
   logic        busy, ov_busy;

   addr_decoder_mr dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (req),
      .addr     (addr),
      .cs       (cs),
      .ready    (ready),
      .bus_err  (bus_err),
      .err_addr (err_addr),
      .err_cnt  (err_cnt),
      .busy     (busy)
   );

   // Region 1 widened to 0x4000-0x4FFF so it overlaps region 0.
   addr_decoder_mr #(
      .BASE ({32'h0000_0000, 32'h0000_8000, 32'h0000_4000, 32'h0000_4000}),
      .MASK ({32'hFFFF_FF00, 32'hFFFF_C000, 32'hFFFF_F000, 32'hFFFF_F800})
   ) dut_ov (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (ov_req),
      .addr     (addr),
      .cs       (ov_cs),
      .ready    (ov_ready),
      .bus_err  (ov_bus_err),
      .err_addr (ov_err_addr),
      .err_cnt  (ov_err_cnt),
      .busy     (ov_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          hit;
      logic [3:0]  cs;
      int unsigned wt;
   } vec_t;

   typedef struct {
      logic [3:0]  cs;
      int unsigned lat;
      bit          hit;
      logic [31:0] err_addr;
      logic [7:0]  err_cnt;
   } exp_t;

   typedef struct {
      logic [3:0]  cs;
      logic        ready;
      logic        bus_err;
      logic        busy;
      logic [31:0] err_addr;
      logic [7:0]  err_cnt;
   } obs_t;

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] m_err_addr [2];
   int          m_err_cnt  [2];
   vec_t        tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   function automatic obs_t get_obs(input bit sel);
      obs_t o;
      o.cs       = sel ? ov_cs       : cs;
      o.ready    = sel ? ov_ready    : ready;
      o.bus_err  = sel ? ov_bus_err  : bus_err;
      o.busy     = sel ? ov_busy     : busy;
      o.err_addr = sel ? ov_err_addr : err_addr;
      o.err_cnt  = sel ? ov_err_cnt  : err_cnt;
      return o;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_cs"},       cs,       0);
      chk({tag, "_ready"},    ready,    0);
      chk({tag, "_bus_err"},  bus_err,  0);
      chk({tag, "_err_addr"}, err_addr, 0);
      chk({tag, "_err_cnt"},  err_cnt,  0);
      chk({tag, "_busy"},     busy,     0);
      chk({tag, "_ov_cs"},    ov_cs,    0);
      chk({tag, "_ov_busy"},  ov_busy,  0);
   endtask

   // One request: expectation queued at drive time, popped when ready/bus_err shows.
   task automatic do_access(input bit sel, input vec_t v, input bit move_addr);
      exp_t e;
      exp_t g;
      obs_t o;
      int   cyc;
      e.cs  = v.hit ? v.cs : 4'b0000;
      e.lat = v.hit ? 1 + v.wt : 1;
      e.hit = v.hit;
      if (!v.hit) begin
         m_err_addr[sel] = v.addr;
         if (m_err_cnt[sel] < 255) m_err_cnt[sel]++;
      end
      e.err_addr = m_err_addr[sel];
      e.err_cnt  = 8'(m_err_cnt[sel]);
      sb.push_back(e);
      addr = v.addr;
      if (sel) ov_req = 1'b1;
      else     req    = 1'b1;
      step;
      if (move_addr) addr = 32'h0000_14F0;
      cyc = 1;
      o   = get_obs(sel);
      while (!(o.ready || o.bus_err) && cyc < 40) begin
         chk("cs_hold", o.cs, e.cs);
         chk("busy_hold", o.busy, 1);
         step;
         cyc++;
         o = get_obs(sel);
      end
      req    = 1'b0;
      ov_req = 1'b0;
      g = sb.pop_front();
      if (!(o.ready || o.bus_err)) begin
         chk("timeout_end_of_access", o.ready | o.bus_err, 1);
      end else begin
         chk("latency",  cyc,        g.lat);
         chk("cs",       o.cs,       g.cs);
         chk("ready",    o.ready,    g.hit);
         chk("bus_err",  o.bus_err,  !g.hit);
         chk("busy",     o.busy,     1);
         chk("err_addr", o.err_addr, g.err_addr);
         chk("err_cnt",  o.err_cnt,  g.err_cnt);
      end
      step;
      o = get_obs(sel);
      chk("cs_after",      o.cs,      0);
      chk("busy_after",    o.busy,    0);
      chk("ready_after",   o.ready,   0);
      chk("bus_err_after", o.bus_err, 0);
   endtask

   initial begin
      vec_t v;
      int   cnt;

      m_err_addr[0] = '0; m_err_addr[1] = '0;
      m_err_cnt[0]  = 0;  m_err_cnt[1]  = 0;

      tbl[0] = '{32'h0000_4600, 1'b1, 4'b0001, 0};
      tbl[1] = '{32'h0000_4800, 1'b0, 4'b0000, 0};
      tbl[2] = '{32'h0000_8010, 1'b1, 4'b0100, 3};
      tbl[3] = '{32'h0000_2ABC, 1'b1, 4'b0010, 1};
      tbl[4] = '{32'h0000_0042, 1'b1, 4'b1000, 0};
      tbl[5] = '{32'h0000_47FF, 1'b1, 4'b0001, 0};
      tbl[6] = '{32'h0000_BFFF, 1'b1, 4'b0100, 3};
      tbl[7] = '{32'h0000_C000, 1'b0, 4'b0000, 0};
      tbl[8] = '{32'h0000_0100, 1'b0, 4'b0000, 0};
      tbl[9] = '{32'h0001_4000, 1'b0, 4'b0000, 0};

      // Reset held with a live request: nothing may leak out.
      rst_n  = 1'b0;
      req    = 1'b1;
      ov_req = 1'b1;
      addr   = 32'h0000_4600;
      repeat (3) step;
      chk_all_zero("rst");
      req    = 1'b0;
      ov_req = 1'b0;
      #2 rst_n = 1'b1;
      step;
      step;
      chk_all_zero("post_rst");

      // Default map, one vector per table row.
      for (int i = 0; i < 10; i++) do_access(1'b0, tbl[i], 1'b0);

      // Overlap: region 0 beats region 1; address change while busy is ignored.
      v = '{32'h0000_4000, 1'b1, 4'b0001, 0};
      do_access(1'b1, v, 1'b0);
      v = '{32'h0000_4900, 1'b1, 4'b0010, 1};
      do_access(1'b1, v, 1'b1);
      v = '{32'h0000_14F0, 1'b0, 4'b0000, 0};
      do_access(1'b1, v, 1'b0);

      // Back-to-back zero-wait accesses: one ready every two cycles.
      addr = 32'h0000_4600;
      req  = 1'b1;
      cnt  = 0;
      for (int i = 1; i <= 20; i++) begin
         step;
         chk("b2b_ready", ready, (i % 2) == 1);
         if (ready) cnt++;
      end
      req = 1'b0;
      chk("b2b_ready_count", cnt, 10);
      step;
      step;
      chk("b2b_idle_busy", busy, 0);

      // Reset in cycle 2 of a 3-wait access aborts it without a ready.
      addr = 32'h0000_8010;
      req  = 1'b1;
      step;
      chk("abort_cs_c1",   cs,   4'b0100);
      chk("abort_busy_c1", busy, 1);
      step;
      #2 rst_n = 1'b0;
      #1;
      chk("abort_cs_async",   cs,   0);
      chk("abort_busy_async", busy, 0);
      req = 1'b0;
      repeat (2) begin
         step;
         chk("abort_ready_in_rst", ready, 0);
      end
      rst_n = 1'b1;
      m_err_addr[0] = '0;
      m_err_cnt[0]  = 0;
      for (int i = 0; i < 6; i++) begin
         step;
         chk("abort_no_ready", ready, 0);
         chk("abort_no_busy",  busy,  0);
         chk("abort_no_cs",    cs,    0);
      end
      chk("abort_err_cnt_clr", err_cnt, 0);

      // Error counter saturates at 255.
      v = '{32'h0000_4800, 1'b0, 4'b0000, 0};
      for (int i = 0; i < 260; i++) do_access(1'b0, v, 1'b0);
      chk("err_cnt_sat", err_cnt, 8'd255);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
